// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares a single UART transmitter between N_REQ byte-stream requesters.
//   A round-robin search picks the next owner. The arbiter then drives the
//   transmitter's start / in-progress / done handshake. The grant stays locked
//   to that owner until its byte flagged "last" has finished. An owner that
//   stops offering bytes for LOCK_TIMEOUT cycles loses the lock.
//
// Ports
//   i_Clk            system clock
//   i_Rst_L          asynchronous, active-low reset
//   i_Req_Valid      per-requester byte available (held until its Ready pulse)
//   i_Req_Data       per-requester byte, requester i in [8*i+:8]
//   i_Req_Last       per-requester "byte ends the message" flag
//   o_Req_Ready      one-cycle pulse, byte of requester i accepted
//   i_TX_InProgress  transmitter busy
//   i_TX_Done        transmitter finished / idle
//   o_TX_Start       one-cycle start pulse to the transmitter
//   o_TX_Byte        byte to send, valid with o_TX_Start and held afterwards
//   o_Grant_Valid    a requester owns the transmitter (including while held)
//   o_Grant_Idx      current / most recent owner
//   o_Lock_Abort     one-cycle pulse, lock dropped by timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter  int N_REQ        = 4,
   parameter  int LOCK_TIMEOUT = 1024,
   localparam int IW           = $clog2(N_REQ),
   localparam int CW           = $clog2(LOCK_TIMEOUT + 1)
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   input  logic [N_REQ-1:0]     i_Req_Valid,
   input  logic [8*N_REQ-1:0]   i_Req_Data,
   input  logic [N_REQ-1:0]     i_Req_Last,
   output logic [N_REQ-1:0]     o_Req_Ready,
   input  logic                 i_TX_InProgress,
   input  logic                 i_TX_Done,
   output logic                 o_TX_Start,
   output logic [7:0]           o_TX_Byte,
   output logic                 o_Grant_Valid,
   output logic [IW-1:0]        o_Grant_Idx,
   output logic                 o_Lock_Abort
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_ACK  = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;
   localparam logic [1:0] HOLD      = 2'd3;

   logic [1:0]       r_State;
   logic [IW-1:0]    r_Ptr;
   logic             r_Last;
   logic [CW-1:0]    r_Cnt;

   logic [IW:0]      w_Search;
   logic             w_Issue;
   logic [IW-1:0]    w_Issue_Idx;
   logic [7:0]       w_Issue_Byte;
   logic [N_REQ-1:0] w_Issue_Onehot;
   logic [IW-1:0]    w_Grant_Next;

   // Round-robin search: the first valid index starting at ptr, wrapping modulo
   // N_REQ. This also works when N_REQ is not a power of two. The MSB of the
   // result flags that a winner was found.
   function automatic logic [IW:0] f_Find(input logic [N_REQ-1:0] valid,
                                          input logic [IW-1:0]    ptr);
      logic [IW:0] res;
      int          j;
      res = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         else            j = j;
         if (!res[IW] && valid[j]) res = {1'b1, IW'(j)};
         else                      res = res;
      end
      return res;
   endfunction

   // Modulo-N_REQ increment used to rotate the priority pointer.
   function automatic logic [IW-1:0] f_Next(input logic [IW-1:0] x);
      return (x == IW'(N_REQ - 1)) ? IW'(0) : x + IW'(1);
   endfunction

   // Pick the issuing requester. In IDLE it comes from the round-robin search.
   // In HOLD it can only be the locked owner.
   always_comb begin
      w_Search     = f_Find(i_Req_Valid, r_Ptr);
      w_Grant_Next = f_Next(o_Grant_Idx);
      if (r_State == HOLD) begin
         w_Issue     = i_Req_Valid[o_Grant_Idx];
         w_Issue_Idx = o_Grant_Idx;
      end else if (r_State == IDLE) begin
         w_Issue     = w_Search[IW];
         w_Issue_Idx = w_Search[IW-1:0];
      end else begin
         w_Issue     = 1'b0;
         w_Issue_Idx = o_Grant_Idx;
      end
      w_Issue_Byte   = i_Req_Data[{w_Issue_Idx, 3'b000} +: 8];
      w_Issue_Onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_Issue_Idx;
   end

   // Arbitration and handshake state machine. All outputs are registered.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State       <= IDLE;
         r_Ptr         <= '0;
         r_Last        <= 1'b0;
         r_Cnt         <= '0;
         o_Req_Ready   <= '0;
         o_TX_Start    <= 1'b0;
         o_TX_Byte     <= 8'h00;
         o_Grant_Valid <= 1'b0;
         o_Grant_Idx   <= '0;
         o_Lock_Abort  <= 1'b0;
      end else begin
         // Start, Ready and Abort are single-cycle pulses.
         o_TX_Start   <= 1'b0;
         o_Req_Ready  <= '0;
         o_Lock_Abort <= 1'b0;

         if (w_Issue) begin
            o_Grant_Idx   <= w_Issue_Idx;
            o_TX_Byte     <= w_Issue_Byte;
            r_Last        <= i_Req_Last[w_Issue_Idx];
            o_Req_Ready   <= w_Issue_Onehot;
            o_TX_Start    <= 1'b1;
            o_Grant_Valid <= 1'b1;
            r_Cnt         <= '0;
            r_State       <= WAIT_ACK;
         end else begin
            case (r_State)
               IDLE: begin
                  r_State <= IDLE;
               end
               WAIT_ACK: begin
                  if (i_TX_InProgress) r_State <= WAIT_DONE;
                  else                 r_State <= WAIT_ACK;
               end
               WAIT_DONE: begin
                  // Done is also high while the transmitter idles. It is only
                  // trusted here, after in-progress has been seen.
                  if (i_TX_Done && r_Last) begin
                     r_Ptr         <= w_Grant_Next;
                     o_Grant_Valid <= 1'b0;
                     r_State       <= IDLE;
                  end else if (i_TX_Done) begin
                     r_Cnt   <= '0;
                     r_State <= HOLD;
                  end else begin
                     r_State <= WAIT_DONE;
                  end
               end
               HOLD: begin
                  // The owner is silent this cycle. Age the lock.
                  if (r_Cnt == CW'(LOCK_TIMEOUT - 1)) begin
                     o_Lock_Abort  <= 1'b1;
                     r_Ptr         <= w_Grant_Next;
                     o_Grant_Valid <= 1'b0;
                     r_Cnt         <= '0;
                     r_State       <= IDLE;
                  end else begin
                     r_Cnt   <= r_Cnt + CW'(1);
                     r_State <= HOLD;
                  end
               end
               default: begin
                  o_Grant_Valid <= 1'b0;
                  r_State       <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (N_REQ=4, LOCK_TIMEOUT=16). A small
//   transmitter model answers each start pulse. It raises in-progress for three
//   cycles and then returns to done, and it logs every byte it was asked to send.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int LT = 16;

   logic          i_Clk = 1'b0;
   logic          i_Rst_L;
   logic [N-1:0]  i_Req_Valid;
   logic [8*N-1:0] i_Req_Data;
   logic [N-1:0]  i_Req_Last;
   logic [N-1:0]  o_Req_Ready;
   logic          i_TX_InProgress;
   logic          i_TX_Done;
   logic          o_TX_Start;
   logic [7:0]    o_TX_Byte;
   logic          o_Grant_Valid;
   logic [1:0]    o_Grant_Idx;
   logic          o_Lock_Abort;

   int            n_cmp  = 0;
   int            n_fail = 0;
   int            tx_cnt;
   logic [7:0]    byte_q[$];

   uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
      .i_Clk           (i_Clk),
      .i_Rst_L         (i_Rst_L),
      .i_Req_Valid     (i_Req_Valid),
      .i_Req_Data      (i_Req_Data),
      .i_Req_Last      (i_Req_Last),
      .o_Req_Ready     (o_Req_Ready),
      .i_TX_InProgress (i_TX_InProgress),
      .i_TX_Done       (i_TX_Done),
      .o_TX_Start      (o_TX_Start),
      .o_TX_Byte       (o_TX_Byte),
      .o_Grant_Valid   (o_Grant_Valid),
      .o_Grant_Idx     (o_Grant_Idx),
      .o_Lock_Abort    (o_Lock_Abort)
   );

   always #5 i_Clk = ~i_Clk;

   // Transmitter model. It shares the reset and goes busy for three cycles after each start.
   always @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         tx_cnt          <= 0;
         i_TX_InProgress <= 1'b0;
         i_TX_Done       <= 1'b1;
      end else if (o_TX_Start) begin
         byte_q.push_back(o_TX_Byte);
         tx_cnt          <= 3;
         i_TX_InProgress <= 1'b1;
         i_TX_Done       <= 1'b0;
      end else if (tx_cnt > 1) begin
         tx_cnt <= tx_cnt - 1;
      end else if (tx_cnt == 1) begin
         tx_cnt          <= 0;
         i_TX_InProgress <= 1'b0;
         i_TX_Done       <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic v, input logic [7:0] b, input logic l);
      i_Req_Valid[idx]      = v;
      i_Req_Data[8*idx +: 8] = b;
      i_Req_Last[idx]       = l;
   endtask

   // Tick until a start pulse is seen. An expired budget counts as a failure.
   task automatic wait_start(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!o_TX_Start && n < 40);
      chk(tag, {31'd0, o_TX_Start}, 32'd1);
   endtask

   // Tick until the grant is released. An expired budget counts as a failure.
   task automatic wait_release(input string tag);
      int n = 0;
      while (o_Grant_Valid && n < 60) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, o_Grant_Valid}, 32'd0);
   endtask

   initial begin
      logic saw;
      i_Rst_L     = 1'b0;
      i_Req_Valid = '0;
      i_Req_Data  = '0;
      i_Req_Last  = '0;
      #2;
      // Reset state
      chk("rst_start", o_TX_Start, 0);
      chk("rst_ready", o_Req_Ready, 0);
      chk("rst_byte", o_TX_Byte, 0);
      chk("rst_gv", o_Grant_Valid, 0);
      chk("rst_idx", o_Grant_Idx, 0);
      chk("rst_abort", o_Lock_Abort, 0);
      tick();
      i_Rst_L = 1'b1;
      tick();

      // Test 1: a single byte from Req0, with exact handshake timing
      set_req(0, 1'b1, 8'h55, 1'b1);
      tick();
      chk("t1_start", o_TX_Start, 1);
      chk("t1_byte", o_TX_Byte, 8'h55);
      chk("t1_ready", o_Req_Ready, 4'b0001);
      chk("t1_gv", o_Grant_Valid, 1);
      chk("t1_idx", o_Grant_Idx, 0);
      set_req(0, 1'b0, 8'h55, 1'b1);
      tick();
      chk("t1_start_pulse", o_TX_Start, 0);
      chk("t1_ready_pulse", o_Req_Ready, 0);
      chk("t1_byte_held", o_TX_Byte, 8'h55);
      tick(); tick(); tick();
      chk("t1_gv_busy", o_Grant_Valid, 1);
      tick();
      chk("t1_gv_rel", o_Grant_Valid, 0);
      chk("t1_idx_kept", o_Grant_Idx, 0);
      chk("t1_log", byte_q[0], 8'h55);
      // The search now starts at 1, so Req1 beats Req0.
      set_req(0, 1'b1, 8'h50, 1'b1);
      set_req(1, 1'b1, 8'h51, 1'b1);
      wait_start("t1_ptr_to");
      chk("t1_ptr_idx", o_Grant_Idx, 1);
      i_Req_Valid = '0;
      wait_release("t1_ptr_rel");
      // Reset again so the pointer is back at 0.
      i_Rst_L = 1'b0;
      #2;
      i_Rst_L = 1'b1;
      tick();

      // Test 2: all four requesters held valid, so grants rotate 0,1,2,3,0
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h20 + 8'(i), 1'b1);
      for (int g = 0; g < 5; g++) begin
         wait_start("t2_to");
         chk("t2_idx", o_Grant_Idx, g % 4);
         chk("t2_byte", o_TX_Byte, 8'h20 + 8'(g % 4));
         chk("t2_ready", o_Req_Ready, 4'b0001 << (g % 4));
         if (g == 4) i_Req_Valid = '0;
         tick();
         chk("t2_ready_pulse", o_Req_Ready, 0);
      end
      wait_release("t2_rel");

      // Test 3: a locked three-byte message from Req1 while Req2 waits
      byte_q.delete();
      set_req(1, 1'b1, 8'hA1, 1'b0);
      set_req(2, 1'b1, 8'hB2, 1'b1);
      wait_start("t3_a1_to");
      chk("t3_a1_idx", o_Grant_Idx, 1);
      chk("t3_a1", o_TX_Byte, 8'hA1);
      set_req(1, 1'b0, 8'hA1, 1'b0);
      tick();
      set_req(1, 1'b1, 8'hA2, 1'b0);
      wait_start("t3_a2_to");
      chk("t3_a2_idx", o_Grant_Idx, 1);
      chk("t3_a2", o_TX_Byte, 8'hA2);
      set_req(1, 1'b0, 8'hA2, 1'b0);
      tick();
      set_req(1, 1'b1, 8'hA3, 1'b1);
      wait_start("t3_a3_to");
      chk("t3_a3_idx", o_Grant_Idx, 1);
      chk("t3_a3", o_TX_Byte, 8'hA3);
      set_req(1, 1'b0, 8'hA3, 1'b1);
      wait_start("t3_b2_to");
      chk("t3_b2_idx", o_Grant_Idx, 2);
      chk("t3_b2", o_TX_Byte, 8'hB2);
      set_req(2, 1'b0, 8'hB2, 1'b1);
      wait_release("t3_rel");
      chk("t3_qlen", byte_q.size(), 4);
      chk("t3_q0", byte_q[0], 8'hA1);
      chk("t3_q1", byte_q[1], 8'hA2);
      chk("t3_q2", byte_q[2], 8'hA3);
      chk("t3_q3", byte_q[3], 8'hB2);

      // Test 4: lock timeout. Req0 goes silent in HOLD and Req3 is waiting.
      set_req(0, 1'b1, 8'h10, 1'b0);
      wait_start("t4_to");
      chk("t4_idx", o_Grant_Idx, 0);
      set_req(0, 1'b0, 8'h10, 1'b0);
      set_req(3, 1'b1, 8'h33, 1'b1);
      saw = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         saw = saw | o_Lock_Abort | o_TX_Start;
      end
      chk("t4_early", saw, 0);
      chk("t4_gv_hold", o_Grant_Valid, 1);
      tick();
      chk("t4_abort", o_Lock_Abort, 1);
      chk("t4_gv", o_Grant_Valid, 0);
      chk("t4_abort_idx", o_Grant_Idx, 0);
      tick();
      chk("t4_abort_pulse", o_Lock_Abort, 0);
      chk("t4_r3_start", o_TX_Start, 1);
      chk("t4_r3_idx", o_Grant_Idx, 3);
      chk("t4_r3_ready", o_Req_Ready, 4'b1000);
      chk("t4_r3_byte", o_TX_Byte, 8'h33);
      set_req(3, 1'b0, 8'h33, 1'b1);
      wait_release("t4_rel");

      // Test 5: with the pointer at 3 (after a Req2 grant), Req3 and Req0 win in that order.
      set_req(2, 1'b1, 8'h22, 1'b1);
      wait_start("t5_pre_to");
      chk("t5_pre_idx", o_Grant_Idx, 2);
      set_req(2, 1'b0, 8'h22, 1'b1);
      wait_release("t5_pre_rel");
      set_req(3, 1'b1, 8'h43, 1'b1);
      set_req(0, 1'b1, 8'h40, 1'b1);
      wait_start("t5_3_to");
      chk("t5_first", o_Grant_Idx, 3);
      set_req(3, 1'b0, 8'h43, 1'b1);
      wait_start("t5_0_to");
      chk("t5_second", o_Grant_Idx, 0);
      set_req(0, 1'b0, 8'h40, 1'b1);
      wait_release("t5_rel");
      set_req(0, 1'b1, 8'h40, 1'b1);
      set_req(1, 1'b1, 8'h41, 1'b1);
      wait_start("t5_ptr1_to");
      chk("t5_ptr1", o_Grant_Idx, 1);
      i_Req_Valid = '0;
      wait_release("t5_ptr1_rel");

      // Test 6: reset asserted in WAIT_DONE, then a normal grant from a fresh pointer
      set_req(0, 1'b1, 8'h66, 1'b1);
      wait_start("t6_to");
      set_req(0, 1'b0, 8'h66, 1'b1);
      tick(); tick(); tick();
      i_Rst_L = 1'b0;
      #1;
      chk("t6_gv", o_Grant_Valid, 0);
      chk("t6_idx", o_Grant_Idx, 0);
      chk("t6_byte", o_TX_Byte, 0);
      chk("t6_start", o_TX_Start, 0);
      chk("t6_ready", o_Req_Ready, 0);
      chk("t6_abort", o_Lock_Abort, 0);
      #2;
      i_Rst_L = 1'b1;
      tick();
      set_req(2, 1'b1, 8'h77, 1'b1);
      tick();
      chk("t6_r2_start", o_TX_Start, 1);
      chk("t6_r2_idx", o_Grant_Idx, 2);
      chk("t6_r2_byte", o_TX_Byte, 8'h77);
      set_req(2, 1'b0, 8'h77, 1'b1);
      wait_release("t6_rel");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
